// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ready handshake and
// presents the latched instruction plus PC+4 to the jump-address aggregator.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [25:0] instr_addr,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        fsm_state
);

  typedef enum logic {
    FETCH  = 1'b0,
    DECODE = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] next_pc;

  // Redirect priority: jump over branch over sequential; targets are word-aligned.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {jump_target[31:2], 2'b00};
    end else if (branch) begin
      next_pc = {branch_target[31:2], 2'b00};
    end
  end

  // Handshake: imem_req stays high with imem_addr stable until a rising edge
  // sees imem_ready=1; that edge transfers imem_rdata. imem_ready is ignored
  // whenever imem_req is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc       <= RESET_PC;
      state    <= FETCH;
      instr    <= 32'h0;
      pc_plus4 <= 32'h0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            instr    <= imem_rdata;
            pc_plus4 <= pc + 32'd4;
            state    <= DECODE;
          end
        end
        DECODE: begin
          if (!stall) begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign imem_req    = rst && (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == DECODE);
  assign instr_addr  = instr[25:0];
  assign fsm_state   = (state == DECODE);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized instruction
// transactions checked against a transaction-level model of the PC sequence.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [25:0] instr_addr;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: address the next fetch must present.
  logic [31:0] exp_pc;
  logic [31:0] exp_q[$];

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .jump(jump), .jump_target(jump_target),
    .branch(branch), .branch_target(branch_target),
    .instr(instr), .instr_addr(instr_addr), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic randomize_dont_care();
    jump          = 1'($urandom);
    branch        = 1'($urandom);
    jump_target   = $urandom;
    branch_target = $urandom;
  endtask

  // Called at a negedge; leaves the DUT in its first FETCH cycle after release.
  task automatic apply_reset(input int hold);
    rst        = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    stall      = 1'($urandom);
    randomize_dont_care();
    #1;
    check("req_in_reset", {31'h0, imem_req}, 32'h0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rst_instr", instr, 32'h0);
      check("rst_valid", {31'h0, instr_valid}, 32'h0);
      check("rst_pc_plus4", pc_plus4, 32'h0);
      check("rst_req", {31'h0, imem_req}, 32'h0);
    end
    rst    = 1'b1;
    exp_pc = RESET_PC;
    #1;
  endtask

  // One instruction transaction: waits ready-low FETCH cycles, then accept,
  // then stalls extra DECODE cycles, then leave DECODE with the given redirect.
  task automatic do_instr(input int waits, input logic [31:0] word, input int stalls,
                          input logic jmp, input logic [31:0] jt,
                          input logic br, input logic [31:0] bt);
    for (int i = 0; i <= waits; i++) begin
      check("fetch_req", {31'h0, imem_req}, 32'h1);
      check("fetch_addr", imem_addr, exp_pc);
      check("fetch_valid", {31'h0, instr_valid}, 32'h0);
      imem_ready = (i == waits);
      imem_rdata = (i == waits) ? word : $urandom;
      stall      = 1'($urandom);
      randomize_dont_care();
      @(negedge clk);
    end
    for (int s = 0; s <= stalls; s++) begin
      check("dec_req", {31'h0, imem_req}, 32'h0);
      check("dec_valid", {31'h0, instr_valid}, 32'h1);
      check("dec_instr", instr, word);
      check("dec_instr_addr", {6'h0, instr_addr}, {6'h0, word[25:0]});
      check("dec_pc_plus4", pc_plus4, exp_pc + 32'd4);
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      if (s < stalls) begin
        stall = 1'b1;
        randomize_dont_care();
      end else begin
        stall         = 1'b0;
        jump          = jmp;
        jump_target   = jt;
        branch        = br;
        branch_target = bt;
      end
      @(negedge clk);
    end
    if (jmp)     exp_pc = jt & 32'hFFFF_FFFC;
    else if (br) exp_pc = bt & 32'hFFFF_FFFC;
    else         exp_pc = exp_pc + 32'd4;
    exp_q.push_back(exp_pc);
  endtask

  initial begin
    stall = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    jump = 1'b0; jump_target = 32'h0; branch = 1'b0; branch_target = 32'h0;
    exp_pc = RESET_PC;

    // Reset then straight fetch
    apply_reset(2);
    do_instr(0, 32'h0000_0001, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    do_instr(0, 32'h0000_0002, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("straight_addr", imem_addr, 32'h0000_0008);

    // Memory wait, then jump to 0x4000_0000
    do_instr(3, 32'h0800_0010, 0, 1'b1, 32'h4000_0000, 1'b0, 32'h0);
    // Jump via aggregator
    do_instr(0, 32'h0800_0010, 0, 1'b1, 32'h4000_0040, 1'b0, 32'h0);
    check("jump_addr", imem_addr, 32'h4000_0040);
    // Priority and alignment
    do_instr(0, 32'h1234_5678, 0, 1'b1, 32'h0000_0103, 1'b1, 32'h0000_0200);
    check("priority_addr", imem_addr, 32'h0000_0100);
    // Branch only, misaligned target
    do_instr(1, 32'h1000_0003, 1, 1'b0, 32'h0, 1'b1, 32'h0000_0207);
    check("branch_addr", imem_addr, 32'h0000_0204);
    // Stall and wrap
    do_instr(0, 32'h0000_0000, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    do_instr(0, 32'hABCD_EF01, 3, 1'b0, 32'h0, 1'b0, 32'h0);
    check("wrap_addr", imem_addr, 32'h0000_0000);

    // Reset mid-FETCH with a ready response in flight
    do_instr(0, 32'h0000_0005, 0, 1'b1, 32'h0000_1000, 1'b0, 32'h0);
    apply_reset(1);
    check("after_reset_addr", imem_addr, RESET_PC);

    // Reset mid-DECODE
    imem_ready = 1'b1; imem_rdata = 32'h7777_0000; stall = 1'b0;
    @(negedge clk);
    check("pre_reset_valid", {31'h0, instr_valid}, 32'h1);
    apply_reset(1);

    // Randomized transactions
    for (int n = 0; n < 300; n++) begin
      do_instr($urandom_range(0, 2), $urandom, $urandom_range(0, 2),
               ($urandom_range(0, 3) == 0), $urandom,
               ($urandom_range(0, 3) == 0), $urandom);
      if ($urandom_range(0, 40) == 0) apply_reset($urandom_range(1, 2));
    end
    check("final_addr", imem_addr, exp_pc);
    check("final_queue_tail", exp_q[$], exp_pc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the MIPS datapath, directly upstream of the jump-address shift-left-2 aggregator. Holds the PC and fetches from instruction memory over a req/ready handshake. Latches the instruction and presents PC+4 and instr[25:0] as the aggregator's inPC/inADDR. Consumes the aggregator's jump target, and a branch target, to select the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low
stall  in  1  hold the current instruction in DECODE
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address (current PC)
imem_ready  in  1  memory has valid imem_rdata this cycle
imem_rdata  in  32  fetched instruction word
jump  in  1  take jump target on DECODE exit
jump_target  in  32  from shift-left-2 aggregator output y
branch  in  1  take branch target on DECODE exit
branch_target  in  32  branch target from branch adder
instr  out  32  latched instruction
instr_addr  out  26  instr[25:0], to aggregator inADDR
pc_plus4  out  32  latched PC+4 of instr, to aggregator inPC
instr_valid  out  1  instr/pc_plus4 hold a valid fetched instruction

Behaviour:
- Reset is decided as: reset rst, synchronous, active-low; clock clk. It is sampled only on the rising edge of clk.
- While rst=0 at a clock edge:
  - pc <= RESET_PC and state <= FETCH.
  - instr <= 0, pc_plus4 <= 0, instr_valid <= 0.
- imem_req is forced to 0 in any cycle where rst=0.
- States:
  - FETCH:
    - imem_req=1, imem_addr=pc, instr_valid=0.
    - If imem_ready=1 at the edge: instr <= imem_rdata, pc_plus4 <= pc+4, go DECODE.
    - Otherwise stay in FETCH with req held and addr stable. There is no timeout.
  - DECODE:
    - imem_req=0, instr_valid=1; instr and pc_plus4 are stable.
    - If stall=1: stay in DECODE. jump and branch are ignored.
    - If stall=0: pc <= next_pc, go FETCH.
- next_pc priority:
  - jump=1: jump_target.
  - else branch=1: branch_target.
  - else: pc_plus4.
- Targets are loaded with bits [1:0] forced to 00.
- jump, branch and both targets are don't-care outside DECODE with stall=0.
- stall is ignored in FETCH.
- instr_addr = instr[25:0] combinationally. It changes only when instr is loaded.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000. No overflow flag.
- Latency: with imem_ready asserted in the first FETCH cycle, each instruction takes 2 cycles (FETCH, DECODE). Each extra ready-low cycle adds 1; each stall cycle adds 1.
- Reset mid-FETCH: the outstanding request is abandoned and any rdata in that cycle is discarded. The next FETCH uses RESET_PC.
- Reset mid-DECODE: the held instruction is dropped and instr_valid falls on that edge.
- Simultaneous jump and branch: jump wins.
- imem_ready outside FETCH is ignored.

Test Plan:
- Reset then straight fetch:
  - Stimulus: rst=0 for 2 cycles, then 1; memory ready every cycle; rdata 0x0000_0001, 0x0000_0002; no jump, branch or stall.
  - Required: imem_addr 0x0, 0x4, 0x8 on successive FETCH cycles; instr_valid toggles 0,1,0,1; pc_plus4 = 0x4 then 0x8.
- Memory wait:
  - Stimulus: imem_ready low for 3 FETCH cycles, then high with rdata 0x0800_0010.
  - Required: req=1 and addr stable for 4 cycles; then instr=0x0800_0010, instr_addr=0x000_0010, instr_valid=1.
- Jump via aggregator:
  - Stimulus: instr 0x0800_0010 at PC 0x4000_0000; jump=1, jump_target=0x4000_0040.
  - Required: next imem_addr=0x4000_0040; pc_plus4 was 0x4000_0004 during DECODE.
- Priority and alignment:
  - Stimulus: jump=1 and branch=1 with jump_target=0x0000_0103, branch_target=0x0000_0200.
  - Required: next imem_addr=0x0000_0100.
- Stall and wrap:
  - Stimulus: PC 0xFFFF_FFFC, stall=1 for 3 DECODE cycles, then stall=0 with no redirect.
  - Required: instr_valid stays 1 and instr is unchanged for 4 cycles; next imem_addr=0x0000_0000.
- Reset mid-operation:
  - Stimulus: rst=0 during a FETCH with imem_ready=1, rdata 0xDEAD_BEEF.
  - Required: instr=0, instr_valid=0, imem_req=0 that cycle; after release imem_addr=RESET_PC.
